// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_MAX_LEN     = 8;
    localparam int unsigned DEF_LEN_W       = 4;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 256;

endpackage

// File: rtl/seq_match_core.sv
// Serial history shift register, fill count and length-masked pattern compare.
// hit is combinational and refers to the bit being shifted in on this edge.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);

    // The oldest history bit is never compared again once shifted, so only
    // MAX_LEN-1 bits are kept; the compare uses the freshly shifted word.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;

    always_comb begin
        hist_shift = {hist_q, x};
        fill_inc   = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_q + 1'b1;
        mask       = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len));
        end
        hit = en && (fill_inc >= len) && ((hist_shift & mask) == (pattern & mask));

        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            if (hit && !overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift[MAX_LEN-2:0];
                fill_d = fill_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_ctrl.sv
// Configurable serial sequence detector: config registers, IDLE/RUN/DONE FSM,
// match counter. Optional RUN inactivity timeout under SEQ_DET_TIMEOUT_EN.
module seq_detector_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN     = DEF_MAX_LEN,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               x,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    if ((2**LEN_W) <= MAX_LEN || MAX_LEN < 2 || TIMEOUT_CYC == 0) begin : g_bad_params
        $error("seq_detector_ctrl: inconsistent MAX_LEN/LEN_W/TIMEOUT_CYC");
    end

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d, len_clamped;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic               cfg_loaded_q, cfg_loaded_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d, cnt_inc;
    logic               y_q, y_d;
    logic               timeout_q, timeout_d;
    logic               cfg_acc, start_acc, run_en, hit, reach_target, tmo_fire;

    // abort outranks every other request on the same edge
    always_comb begin
        cfg_acc      = cfg_valid && cfg_ready && !abort;
        start_acc    = start && !abort &&
                       (((state_q == IDLE) && (cfg_loaded_q || cfg_acc)) || (state_q == DONE));
        run_en       = (state_q == RUN) && !abort;
        cnt_inc      = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + 1'b1;
        reach_target = hit && (target_q != '0) && (cnt_inc == target_q);
        if (cfg_len == '0)
            len_clamped = LEN_W'(1);
        else if (cfg_len > LEN_W'(MAX_LEN))
            len_clamped = LEN_W'(MAX_LEN);
        else
            len_clamped = cfg_len;
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (run_en),
        .clr     (start_acc),
        .x       (x),
        .pattern (pattern_q),
        .len     (len_q),
        .overlap (overlap_q),
        .hit     (hit)
    );

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // a match on the expiry edge wins and restarts the count
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_fire  = 1'b0;
        if (start_acc) begin
            tmo_cnt_d = '0;
        end else if (run_en) begin
            if (hit) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                tmo_fire  = 1'b1;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_acc) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (reach_target || tmo_fire) state_d = DONE;
            DONE:    if (abort) state_d = IDLE;
                     else if (start_acc) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == IDLE) || (state_q == DONE);
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        y         = y_q;
        match_cnt = match_cnt_q;
        timeout   = timeout_q;
    end

    always_comb begin
        pattern_d    = cfg_acc ? cfg_pattern : pattern_q;
        len_d        = cfg_acc ? len_clamped : len_q;
        overlap_d    = cfg_acc ? cfg_overlap : overlap_q;
        target_d     = cfg_acc ? cfg_target  : target_q;
        cfg_loaded_d = cfg_loaded_q || cfg_acc;
        y_d          = run_en && hit;
        match_cnt_d  = match_cnt_q;
        timeout_d    = timeout_q;
        if (cfg_acc || start_acc) begin
            match_cnt_d = '0;
            timeout_d   = 1'b0;
        end else begin
            if (run_en && hit) match_cnt_d = cnt_inc;
            if (tmo_fire)      timeout_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q    <= '0;
            len_q        <= LEN_W'(1);
            overlap_q    <= 1'b0;
            target_q     <= '0;
            cfg_loaded_q <= 1'b0;
            match_cnt_q  <= '0;
            y_q          <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            pattern_q    <= pattern_d;
            len_q        <= len_d;
            overlap_q    <= overlap_d;
            target_q     <= target_d;
            cfg_loaded_q <= cfg_loaded_d;
            match_cnt_q  <= match_cnt_d;
            y_q          <= y_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_seq_detector_ctrl.sv
// Scoreboard bench for seq_detector_ctrl: directed streams push expected y pulses,
// a negedge monitor pops and checks them; status outputs are checked inline.
module tb_seq_detector_ctrl;

    localparam int unsigned MAX_LEN     = 8;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               x = 1'b0;
    logic               y;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
    logic               timeout;

    typedef struct {
        int bit_no;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   bit_idx = 0;

    seq_detector_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .LEN_W       (LEN_W),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .y           (y),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && y) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_y: pulse after bit %0d cnt %0d, required none", bit_idx, match_cnt);
            end else begin
                e = exp_q.pop_front();
                check("y_bit", bit_idx, e.bit_no);
                check("y_cnt", int'(match_cnt), e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input int c);
        exp_t e;
        e.bit_no = b;
        e.cnt    = c;
        exp_q.push_back(e);
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                            input logic ovl, input logic [CNT_W-1:0] tgt);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_target  = tgt;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        bit_idx = 0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) begin
            x = v[i];
            tick();
            bit_idx++;
        end
        x = 1'b0;
    endtask

    task automatic drained(input string name);
        @(negedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        // T1: reset values, start without config, reset in the middle of RUN
        #2 rst_n = 1'b0;
        #2;
        check("rst_y", int'(y), 0);
        check("rst_cnt", int'(match_cnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        do_start();
        check("start_noload_busy", int'(busy), 0);

        load_cfg(8'b1111_1011, 4'd4, 1'b1, 8'd0);
        do_start();
        check("run_busy", int'(busy), 1);
        check("run_cfg_ready", int'(cfg_ready), 0);
        push(4, 1);
        send_bits(16'b1011, 4);
        drained("t1_drain");
        check("t1_cnt_pre", int'(match_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_cnt", int'(match_cnt), 0);
        check("arst_y", int'(y), 0);
        check("arst_done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        do_start();
        check("start_after_rst_busy", int'(busy), 0);

        // T2: overlapping 1011 with upper pattern bits masked by len
        load_cfg(8'b1111_1011, 4'd4, 1'b1, 8'd0);
        do_start();
        push(4, 1);
        push(7, 2);
        send_bits(16'b1011011, 7);
        drained("t2_drain");
        check("t2_cnt", int'(match_cnt), 2);
        check("t2_busy", int'(busy), 1);
        do_abort();
        check("t2_abort_busy", int'(busy), 0);
        check("t2_abort_cnt", int'(match_cnt), 2);

        // T3: non-overlapping
        load_cfg(8'b0000_1011, 4'd4, 1'b0, 8'd0);
        check("t3_cfg_clears_cnt", int'(match_cnt), 0);
        do_start();
        push(4, 1);
        send_bits(16'b1011011, 7);
        drained("t3_drain");
        check("t3_cnt", int'(match_cnt), 1);
        do_abort();

        // T4: target count reached
        load_cfg(8'b0000_0111, 4'd3, 1'b1, 8'd2);
        do_start();
        push(4, 1);
        push(5, 2);
        send_bits(16'b011110, 6);
        drained("t4_drain");
        check("t4_cnt", int'(match_cnt), 2);
        check("t4_busy", int'(busy), 0);
        check("t4_done", int'(done), 1);
        check("t4_timeout", int'(timeout), 0);
        check("t4_cfg_ready", int'(cfg_ready), 1);

        // T5: abort on the second match edge, then length 0 and length 12
        do_start();
        check("t5_restart_busy", int'(busy), 1);
        check("t5_restart_cnt", int'(match_cnt), 0);
        push(3, 1);
        send_bits(16'b111, 3);
        x = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        x = 1'b0;
        bit_idx++;
        check("t5_abort_busy", int'(busy), 0);
        check("t5_abort_done", int'(done), 0);
        check("t5_abort_cnt", int'(match_cnt), 1);
        drained("t5_drain");
        check("t5_abort_y", int'(y), 0);

        load_cfg(8'b0000_0001, 4'd0, 1'b1, 8'd0);
        do_start();
        push(2, 1);
        push(3, 2);
        send_bits(16'b011, 3);
        drained("len0_drain");
        check("len0_cnt", int'(match_cnt), 2);
        do_abort();

        load_cfg(8'b1010_0110, 4'd12, 1'b1, 8'd0);
        do_start();
        push(12, 1);
        send_bits(16'b0110_1010_0110, 12);
        drained("len12_drain");
        check("len12_cnt", int'(match_cnt), 1);
        do_abort();

`ifdef SEQ_DET_TIMEOUT_EN
        // T6: inactivity timeout
        load_cfg(8'b0000_0111, 4'd3, 1'b1, 8'd0);
        do_start();
        send_bits(16'h0000, 15);
        check("t6_busy_before", int'(busy), 1);
        check("t6_done_before", int'(done), 0);
        send_bits(16'h0000, 1);
        check("t6_done", int'(done), 1);
        check("t6_timeout", int'(timeout), 1);
        check("t6_busy", int'(busy), 0);
        do_start();
        check("t6_restart_done", int'(done), 0);
        check("t6_restart_timeout", int'(timeout), 0);
        check("t6_restart_busy", int'(busy), 1);
        do_abort();
`endif

        drained("final_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
